// File: rtl/mpu_controller_if.sv
// Operation types and the request/unit-handshake bundle
// between the MPU controller and its neighbours.
package mpu_pkg;
    typedef enum logic [2:0] {
        OP_NOP    = 3'd0,
        OP_LOAD   = 3'd1,
        OP_STORE  = 3'd2,
        OP_MATMUL = 3'd3,
        OP_ADD    = 3'd4
    } mpu_operation_t;
endpackage

interface mpu_if #(
    parameter int MBITS = 2,
    parameter int NBITS = 2,
    parameter int AW    = 2
);
    logic                       req;
    logic                       ready;
    mpu_pkg::mpu_operation_t    op;
    logic [MBITS:0]             m_in;
    logic [NBITS:0]             n_in;
    logic [AW-1:0]              addr;
    logic                       load_en;
    logic [MBITS:0]             load_m_size;
    logic [NBITS:0]             load_n_size;
    logic [AW-1:0]              load_addr;
    logic                       load_ack;
    logic                       load_error;
    logic                       store_en;
    logic [AW-1:0]              store_addr;
    logic                       store_ack;
    logic                       done;
    logic                       error;
    logic [2:0]                 err_code;
    logic [2**AW-1:0]           reg_valid;

    modport slave (
        input  req, op, m_in, n_in, addr,
        input  load_ack, load_error, store_ack,
        output ready, load_en, load_m_size, load_n_size, load_addr,
        output store_en, store_addr, done, error, err_code, reg_valid
    );

    modport master (
        output req, op, m_in, n_in, addr,
        output load_ack, load_error, store_ack,
        input  ready, load_en, load_m_size, load_n_size, load_addr,
        input  store_en, store_addr, done, error, err_code, reg_valid
    );
endinterface

// File: rtl/mpu_controller.sv
// MPU front-end: validates requests, drives the load/store units
// with a bounded wait, reports one done/error pulse per operation.
module mpu_controller
    import mpu_pkg::*;
#(
    parameter int M               = 4,
    parameter int N               = 4,
    parameter int MBITS           = $clog2(M),
    parameter int NBITS           = $clog2(N),
    parameter int MATRIX_REG_SIZE = 2,
    parameter int TIMEOUT         = 64
) (
    input logic clk,
    input logic rst,
    mpu_if.slave bus
);
    localparam int R = 2 ** MATRIX_REG_SIZE;
    localparam logic [MBITS:0] M_LIM   = (MBITS + 1)'(M);
    localparam logic [NBITS:0] N_LIM   = (NBITS + 1)'(N);
    localparam logic [7:0]     TO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        LOAD_WAIT,
        STORE_WAIT,
        RESP
    } state_t;

    state_t                     state_q, state_d;
    mpu_operation_t             op_q, op_d;
    logic [MBITS:0]             m_q, m_d;
    logic [NBITS:0]             n_q, n_d;
    logic [MATRIX_REG_SIZE-1:0] addr_q, addr_d;
    logic [7:0]                 cnt_q, cnt_d;
    logic [2:0]                 res_q, res_d;
    logic [R-1:0]               rv_q, rv_d;
    logic                       size_bad;

    assign size_bad = (m_q == '0) || (n_q == '0) ||
                      (m_q > M_LIM) || (n_q > N_LIM);

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        m_d     = m_q;
        n_d     = n_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        rv_d    = rv_q;
        unique case (state_q)
            IDLE: begin
                if (bus.req) begin
                    op_d    = bus.op;
                    m_d     = bus.m_in;
                    n_d     = bus.n_in;
                    addr_d  = bus.addr;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                res_d   = 3'd0;
                cnt_d   = 8'd0;
                state_d = RESP;
                unique case (1'b1)
                    (op_q == OP_NOP): ;
                    (op_q == OP_LOAD): begin
                        if (size_bad) res_d = 3'd2;
                        else          state_d = LOAD_WAIT;
                    end
                    (op_q == OP_STORE): begin
                        if (!rv_q[addr_q]) res_d = 3'd3;
                        else               state_d = STORE_WAIT;
                    end
                    default: res_d = 3'd1;
                endcase
            end
            LOAD_WAIT: begin
                cnt_d = cnt_q + 8'd1;
                // a failed or abandoned load may have half-written the register
                if (bus.load_error) begin
                    res_d        = 3'd4;
                    rv_d[addr_q] = 1'b0;
                    state_d      = RESP;
                end else if (bus.load_ack) begin
                    res_d        = 3'd0;
                    rv_d[addr_q] = 1'b1;
                    state_d      = RESP;
                end else if (cnt_q == TO_LAST) begin
                    res_d        = 3'd5;
                    rv_d[addr_q] = 1'b0;
                    state_d      = RESP;
                end
            end
            STORE_WAIT: begin
                cnt_d = cnt_q + 8'd1;
                if (bus.store_ack) begin
                    res_d   = 3'd0;
                    state_d = RESP;
                end else if (cnt_q == TO_LAST) begin
                    res_d   = 3'd5;
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= OP_NOP;
            m_q     <= '0;
            n_q     <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            rv_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            m_q     <= m_d;
            n_q     <= n_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            rv_q    <= rv_d;
        end
    end

    assign bus.ready       = (state_q == IDLE);
    assign bus.load_en     = (state_q == LOAD_WAIT);
    assign bus.load_m_size = m_q;
    assign bus.load_n_size = n_q;
    assign bus.load_addr   = addr_q;
    assign bus.store_en    = (state_q == STORE_WAIT);
    assign bus.store_addr  = addr_q;
    assign bus.done        = (state_q == RESP) && (res_q == 3'd0);
    assign bus.error       = (state_q == RESP) && (res_q != 3'd0);
    assign bus.err_code    = bus.error ? res_q : 3'd0;
    assign bus.reg_valid   = rv_q;
endmodule

// File: tb/tb_mpu_controller.sv
// Directed checks of the MPU controller: accept/response timing,
// rejects, unit failures, timeouts and reset abort.
module tb_mpu_controller;
    import mpu_pkg::*;

    localparam int M  = 4;
    localparam int N  = 4;
    localparam int MB = 2;
    localparam int NB = 2;
    localparam int RS = 2;
    localparam int TO = 64;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mpu_if #(.MBITS(MB), .NBITS(NB), .AW(RS)) bus ();

    mpu_controller #(
        .M(M), .N(N), .MBITS(MB), .NBITS(NB),
        .MATRIX_REG_SIZE(RS), .TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    int r_en, r_st, r_lat, r_ackk;
    logic r_done, r_err, r_hold, r_ec, r_rdy, r_after;
    logic [2:0] r_code;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // issue one request, play the unit side, return at the next idle cycle
    task automatic run_op(input mpu_operation_t o, input int m, input int n,
                          input int a, input int ack_at, input int err_at);
        bit fin;
        r_en = 0; r_st = 0; r_lat = 0; r_ackk = 0;
        r_done = 0; r_err = 0; r_code = 0; r_hold = 1; r_ec = 1;
        fin = 0;
        @(negedge clk);
        bus.req  = 1'b1;
        bus.op   = o;
        bus.m_in = m[MB:0];
        bus.n_in = n[NB:0];
        bus.addr = a[RS-1:0];
        @(negedge clk);
        bus.req = 1'b0;
        for (int k = 1; k <= 300 && !fin; k++) begin
            bus.load_ack   = 1'b0;
            bus.load_error = 1'b0;
            bus.store_ack  = 1'b0;
            if (!bus.error && bus.err_code != 3'd0) r_ec = 1'b0;
            if (bus.done || bus.error) begin
                r_done = bus.done;
                r_err  = bus.error;
                r_code = bus.err_code;
                r_lat  = k;
                fin    = 1;
            end else begin
                if (bus.load_en) begin
                    r_en++;
                    if (bus.load_m_size != m[MB:0] ||
                        bus.load_n_size != n[NB:0] ||
                        bus.load_addr != a[RS-1:0]) r_hold = 1'b0;
                    if (r_en == ack_at) begin
                        bus.load_ack = 1'b1;
                        r_ackk = k;
                    end
                    if (r_en == err_at) bus.load_error = 1'b1;
                end
                if (bus.store_en) begin
                    r_st++;
                    if (bus.store_addr != a[RS-1:0]) r_hold = 1'b0;
                    if (r_st == ack_at) begin
                        bus.store_ack = 1'b1;
                        r_ackk = k;
                    end
                end
                @(negedge clk);
            end
        end
        if (!fin) check("op_no_response", 32'd0, 32'd1);
        @(negedge clk);
        r_rdy   = bus.ready;
        r_after = bus.done | bus.error;
    endtask

    initial begin
        rst            = 1'b1;
        bus.req        = 1'b0;
        bus.op         = OP_NOP;
        bus.m_in       = '0;
        bus.n_in       = '0;
        bus.addr       = '0;
        bus.load_ack   = 1'b0;
        bus.load_error = 1'b0;
        bus.store_ack  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_ready", bus.ready, 1);
        check("rst_load_en", bus.load_en, 0);
        check("rst_store_en", bus.store_en, 0);
        check("rst_done", bus.done, 0);
        check("rst_error", bus.error, 0);
        check("rst_err_code", bus.err_code, 0);
        check("rst_reg_valid", bus.reg_valid, 0);
        check("rst_load_m", bus.load_m_size, 0);

        run_op(OP_NOP, 0, 0, 0, 0, 0);
        check("nop_done", r_done, 1);
        check("nop_error", r_err, 0);
        check("nop_latency", r_lat, 2);
        check("nop_ready_after", r_rdy, 1);
        check("nop_single_pulse", r_after, 0);

        run_op(OP_LOAD, 2, 2, 0, 4, 0);
        check("ld0_done", r_done, 1);
        check("ld0_en_cycles", r_en, 4);
        check("ld0_fields_held", r_hold, 1);
        check("ld0_ack_to_done", r_lat, r_ackk + 1);
        check("ld0_reg_valid", bus.reg_valid, 4'b0001);

        run_op(OP_STORE, 0, 0, 1, 1, 0);
        check("st1_error", r_err, 1);
        check("st1_code", r_code, 3);
        check("st1_store_en", r_st, 0);

        run_op(OP_LOAD, M + 1, 2, 2, 1, 0);
        check("ld_bigm_code", r_code, 2);
        check("ld_bigm_load_en", r_en, 0);

        run_op(OP_LOAD, 2, 0, 2, 1, 0);
        check("ld_n0_code", r_code, 2);
        check("ld_n0_reg_valid", bus.reg_valid, 4'b0001);

        run_op(OP_LOAD, 4, 4, 2, 1, 0);
        check("ld2_done", r_done, 1);
        check("ld2_reg_valid", bus.reg_valid, 4'b0101);

        run_op(OP_LOAD, 1, 3, 2, 2, 2);
        check("ld2_err_code", r_code, 4);
        check("ld2_err_done", r_done, 0);
        check("ld2_err_reg_valid", bus.reg_valid, 4'b0001);

        run_op(OP_MATMUL, 1, 1, 0, 1, 0);
        check("illegal_code", r_code, 1);
        check("illegal_no_units", r_en + r_st, 0);

        run_op(OP_STORE, 0, 0, 0, 2, 0);
        check("st0_done", r_done, 1);
        check("st0_en_cycles", r_st, 2);
        check("st0_addr_held", r_hold, 1);
        check("st0_reg_valid", bus.reg_valid, 4'b0001);

        run_op(OP_LOAD, 3, 1, 3, 1, 0);
        check("ld3_reg_valid", bus.reg_valid, 4'b1001);

        run_op(OP_LOAD, 3, 1, 3, 0, 0);
        check("ld3_to_code", r_code, 5);
        check("ld3_to_en_cycles", r_en, TO);
        check("ld3_to_reg_valid", bus.reg_valid, 4'b0001);

        run_op(OP_LOAD, 2, 4, 1, TO, 0);
        check("ld1_lastack_done", r_done, 1);
        check("ld1_lastack_en", r_en, TO);
        check("ld1_lastack_rv", bus.reg_valid, 4'b0011);

        run_op(OP_STORE, 0, 0, 0, 0, 0);
        check("st0_to_code", r_code, 5);
        check("st0_to_en_cycles", r_st, TO);
        check("err_code_quiet", r_ec, 1);

        @(negedge clk);
        bus.load_ack   = 1'b1;
        bus.load_error = 1'b1;
        bus.store_ack  = 1'b1;
        @(negedge clk);
        bus.load_ack   = 1'b0;
        bus.load_error = 1'b0;
        bus.store_ack  = 1'b0;
        check("idle_ack_pulse", bus.done | bus.error, 0);
        check("idle_ack_ready", bus.ready, 1);
        check("idle_ack_rv", bus.reg_valid, 4'b0011);

        @(negedge clk);
        bus.req  = 1'b1;
        bus.op   = OP_LOAD;
        bus.m_in = 3'd1;
        bus.n_in = 3'd1;
        bus.addr = 2'd2;
        @(negedge clk);
        bus.req = 1'b0;
        @(negedge clk);
        check("abort_in_wait", bus.load_en, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_load_en", bus.load_en, 0);
        check("abort_pulse", bus.done | bus.error, 0);
        check("abort_ready", bus.ready, 1);
        check("abort_reg_valid", bus.reg_valid, 0);
        @(negedge clk);
        check("abort_no_late_pulse", bus.done | bus.error, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mpu_controller.md
MPU_CONTROLLER -- requirements
Module: mpu_controller

Interface
REQ-001 Parameter M, default 4, max matrix rows.
REQ-002 Parameter N, default 4, max matrix columns.
REQ-003 Parameter MBITS, default $clog2(M); NBITS, default $clog2(N).
REQ-004 Parameter MATRIX_REG_SIZE, default 2, register-file address width; R = 2**MATRIX_REG_SIZE registers.
REQ-005 Parameter TIMEOUT, default 64, max wait cycles for unit ack, range 2..255.
REQ-006 clk  in  1  sole clock; all logic on rising edge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 req  in  1  operation request; valid with op/m_in/n_in/addr.
REQ-009 ready  out  1  controller can accept; a transfer occurs when req&&ready.
REQ-010 op  in  mpu_operation_t  requested operation (NOP, LOAD, STORE handled; anything else illegal).
REQ-011 m_in  in  MBITS+1  row count; n_in  in  NBITS+1  column count.
REQ-012 addr  in  MATRIX_REG_SIZE  target matrix register.
REQ-013 load_en  out  1  enable to load unit; load_m_size, load_n_size, load_addr  out  latched size/address.
REQ-014 load_ack  in  1  load unit done; load_error  in  1  load unit failure.
REQ-015 store_en  out  1  enable to store path; store_addr  out  MATRIX_REG_SIZE.
REQ-016 store_ack  in  1  store path done.
REQ-017 done  out  1  one-cycle pulse, operation completed successfully.
REQ-018 error  out  1  one-cycle pulse, operation rejected or failed; err_code  out  3  cause, valid with error.
REQ-019 reg_valid  out  R  per-register "holds a loaded matrix" flags.

Function
REQ-020 FSM states IDLE, CHECK, LOAD_WAIT, STORE_WAIT, RESP; ready=1 only in IDLE.
REQ-021 IDLE: on req&&ready latch op/m_in/n_in/addr, go CHECK next cycle; req without ready ignored.
REQ-022 CHECK (one cycle): NOP -> RESP success; illegal op -> RESP err_code 1; LOAD with m_in=0, n_in=0, m_in>M or n_in>N -> RESP err_code 2; STORE with reg_valid[addr]=0 -> RESP err_code 3; else LOAD -> LOAD_WAIT, STORE -> STORE_WAIT.
REQ-023 load_en=1 throughout LOAD_WAIT only; load_* outputs hold latched values whenever load_en=1.
REQ-024 store_en=1 throughout STORE_WAIT only; store_addr holds latched addr.
REQ-025 Wait counter cleared on entering a WAIT state, increments each WAIT cycle; ack or error observed on cycle k leaves WAIT next edge.
REQ-026 LOAD_WAIT: load_error=1 -> RESP err_code 4 (error wins over simultaneous load_ack); load_ack=1 -> RESP success.
REQ-027 Timeout: counter reaching TIMEOUT-1 with no ack/error -> RESP err_code 5; ack on that same cycle wins (success).
REQ-028 RESP (one cycle): done=1 xor error=1 per outcome, then IDLE.
REQ-029 reg_valid[addr] set at LOAD success; cleared at load_error or load timeout (partial write); unchanged by STORE/NOP/rejects.
REQ-030 Latency: NOP accepted edge T -> done high cycle T+2, ready high T+3; LOAD ack at cycle A -> done at A+1.
REQ-031 load_ack/store_ack/load_error outside the matching WAIT state ignored.
REQ-032 err_code=0 whenever error=0.

Reset
REQ-033 rst=1 at edge: state IDLE, ready=1 next cycle, load_en=store_en=done=error=0, err_code=0, reg_valid=0, counter=0, latched fields 0.
REQ-034 rst mid-operation (any WAIT state) aborts without done/error pulse; reg_valid cleared.

Verification
REQ-035 After reset, NOP req -> done pulse 2 cycles after accept, error never asserts, ready back cycle after done.
REQ-036 LOAD m=2 n=2 addr=0, ack after 3 cycles of load_en -> load_m_size=2, load_addr=0 held, done pulse, reg_valid=0001.
REQ-037 STORE addr=1 with reg_valid[1]=0 -> error, err_code=3, store_en never asserts.
REQ-038 LOAD m=M+1 -> err_code 2, load_en never asserts; LOAD with load_ack and load_error same cycle -> err_code 4, reg_valid[addr]=0.
REQ-039 LOAD with no ack, TIMEOUT=64 -> load_en high exactly 64 cycles, err_code 5; repeat with ack on cycle 64 -> done.
REQ-040 rst asserted during LOAD_WAIT -> load_en low next cycle, no done/error, ready=1, reg_valid=0.
